icache_refill_ctrl: RTL and testbench

//  Direct-mapped instruction cache between CPU fetch stage and block instruction memory.

---
 rtl/icache_refill_ctrl_pkg.sv | 22 ++
 rtl/icache_refill_ctrl_line_store.sv | 48 ++++
 rtl/icache_refill_ctrl.sv | 118 +++++++++++
 tb/tb_icache_refill_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_refill_ctrl_pkg.sv
// Shared widths, FSM state type and word-select helper for the instruction cache refill controller.
package icache_pkg;

  localparam int ADDR_W     = 32;
  localparam int MEM_ADDR_W = 28;
  localparam int BLOCK_BITS = 128;
  localparam int WORD_SEL_W = 2;
  localparam int WORD_W     = 32;
  localparam int OFFSET_W   = 4;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MEM_READ = 2'd1,
    S_FILL     = 2'd2
  } state_t;

  function automatic logic [WORD_W-1:0] word_sel(input logic [BLOCK_BITS-1:0] blk,
                                                 input logic [WORD_SEL_W-1:0] sel);
    return blk[sel*WORD_W +: WORD_W];
  endfunction

endpackage

// File: rtl/icache_refill_ctrl_line_store.sv
// Valid/tag/data storage for the direct-mapped cache: async read, one write port,
// flash invalidate that overrides a concurrent write's valid set.
module icache_line_store #(
  parameter int NUM_SETS = 8,
  parameter int IDX_W    = 3,
  parameter int TAG_W    = 25,
  parameter int DATA_W   = 128
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic [IDX_W-1:0]  i_rd_idx,
  output logic              o_rd_valid,
  output logic [TAG_W-1:0]  o_rd_tag,
  output logic [DATA_W-1:0] o_rd_data,
  input  logic              i_wr_en,
  input  logic [IDX_W-1:0]  i_wr_idx,
  input  logic [TAG_W-1:0]  i_wr_tag,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_inval_all
);

  logic [NUM_SETS-1:0] r_valid;
  logic [TAG_W-1:0]    r_tag  [NUM_SETS];
  logic [DATA_W-1:0]   r_data [NUM_SETS];

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_valid <= '0;
    end else if (i_inval_all) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[i_wr_idx] <= 1'b1;
    end
  end

  // Tag/data contents are meaningless until valid is set, so they are never reset.
  always_ff @(posedge i_clock) begin
    if (i_wr_en) begin
      r_tag[i_wr_idx]  <= i_wr_tag;
      r_data[i_wr_idx] <= i_wr_data;
    end
  end

  assign o_rd_valid = r_valid[i_rd_idx];
  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_data  = r_data[i_rd_idx];

endmodule

// File: rtl/icache_refill_ctrl.sv
// Direct-mapped instruction cache controller: combinational hit path, block refill FSM
// that acts as memory read initiator, and whole-cache flush (deferred while a refill runs).
module icache_refill_ctrl
  import icache_pkg::*;
#(
  parameter  int NUM_SETS = 8,
  localparam int IDX_W    = $clog2(NUM_SETS),
  localparam int TAG_W    = ADDR_W - OFFSET_W - IDX_W
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  input  logic [ADDR_W-1:0]     i_address,
  input  logic                  i_read,
  output logic [WORD_W-1:0]     o_instruction,
  output logic                  o_busywait,
  input  logic                  i_flush,
  output logic                  o_mem_read,
  output logic [MEM_ADDR_W-1:0] o_mem_address,
  input  logic [BLOCK_BITS-1:0] i_mem_readdata,
  input  logic                  i_mem_busywait
);

  state_t r_state;
  state_t w_state_nxt;

  logic [MEM_ADDR_W-1:0] r_mem_address;
  logic [IDX_W-1:0]      r_idx;
  logic [TAG_W-1:0]      r_tag;
  logic                  r_flush_pend;

  logic [WORD_SEL_W-1:0] w_word;
  logic [IDX_W-1:0]      w_idx;
  logic [TAG_W-1:0]      w_tag;
  logic                  w_rd_valid;
  logic [TAG_W-1:0]      w_rd_tag;
  logic [BLOCK_BITS-1:0] w_rd_data;
  logic                  w_hit;
  logic                  w_fill;
  logic                  w_inval_all;
  logic                  w_start_miss;

  assign w_word = i_address[OFFSET_W-1:2];
  assign w_idx  = i_address[OFFSET_W +: IDX_W];
  assign w_tag  = i_address[ADDR_W-1 -: TAG_W];

  // A flush cycle never hits: the lines are being invalidated at the coming edge.
  assign w_hit = i_read & w_rd_valid & (w_rd_tag == w_tag) & (r_state == S_IDLE) & ~i_flush;

  assign w_start_miss = (r_state == S_IDLE) & (w_state_nxt == S_MEM_READ);
  assign w_fill       = (r_state == S_FILL);
  assign w_inval_all  = ((r_state == S_IDLE) & i_flush) | (w_fill & (r_flush_pend | i_flush));

  icache_line_store #(
    .NUM_SETS (NUM_SETS),
    .IDX_W    (IDX_W),
    .TAG_W    (TAG_W),
    .DATA_W   (BLOCK_BITS)
  ) u_line_store (
    .i_clock     (i_clock),
    .i_reset_n   (i_reset_n),
    .i_rd_idx    (w_idx),
    .o_rd_valid  (w_rd_valid),
    .o_rd_tag    (w_rd_tag),
    .o_rd_data   (w_rd_data),
    .i_wr_en     (w_fill),
    .i_wr_idx    (r_idx),
    .i_wr_tag    (r_tag),
    .i_wr_data   (i_mem_readdata),
    .i_inval_all (w_inval_all)
  );

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (i_read && !w_hit && !i_flush) w_state_nxt = S_MEM_READ;
      S_MEM_READ: if (!i_mem_busywait)              w_state_nxt = S_FILL;
      S_FILL:                                       w_state_nxt = S_IDLE;
      default:                                      w_state_nxt = S_IDLE;
    endcase
  end

  // Miss context is captured once; later PC changes during the refill are ignored.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_mem_address <= '0;
      r_idx         <= '0;
      r_tag         <= '0;
      r_flush_pend  <= 1'b0;
    end else begin
      if (w_start_miss) begin
        r_mem_address <= i_address[ADDR_W-1:OFFSET_W];
        r_idx         <= w_idx;
        r_tag         <= w_tag;
      end
      if (w_fill) begin
        r_flush_pend <= 1'b0;
      end else if (i_flush && (r_state != S_IDLE)) begin
        r_flush_pend <= 1'b1;
      end
    end
  end

  always_comb begin
    o_mem_read    = (r_state == S_MEM_READ);
    o_mem_address = r_mem_address;
    o_busywait    = i_reset_n & ((i_read & ~w_hit) | (r_state != S_IDLE));
    o_instruction = w_hit ? word_sel(w_rd_data, w_word) : '0;
  end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Bench for icache_refill_ctrl: 16-beat block memory model, directed scenarios and
// random fetch/flush traffic checked against a tag/valid lookup model.
module tb_icache_refill_ctrl;

  logic         clk;
  logic         rst_n;
  logic [31:0]  address;
  logic         read;
  logic         flush;
  logic [31:0]  instruction;
  logic         busywait;
  logic         mem_read;
  logic [27:0]  mem_address;
  logic [127:0] mem_readdata;
  logic         mem_busywait;

  int n_checks;
  int n_fail;

  icache_refill_ctrl dut (
    .i_clock        (clk),
    .i_reset_n      (rst_n),
    .i_address      (address),
    .i_read         (read),
    .o_instruction  (instruction),
    .o_busywait     (busywait),
    .i_flush        (flush),
    .o_mem_read     (mem_read),
    .o_mem_address  (mem_address),
    .i_mem_readdata (mem_readdata),
    .i_mem_busywait (mem_busywait)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Block memory: 16 beats per request, data stable only once busywait falls.
  logic [127:0] mem_blk [64];
  logic [3:0]   beat;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) beat <= 4'd0;
    else if (mem_read) beat <= beat + 4'd1;
  end

  assign mem_busywait = mem_read && (beat != 4'd15);
  assign mem_readdata = mem_busywait ? {4{32'hBAD0BAD0}} : mem_blk[mem_address[5:0]];

  // Reference: per-set valid bit and stored tag, tracked from access outcomes.
  bit          m_valid [8];
  int unsigned m_tag   [8];

  function automatic bit model_hit(input logic [31:0] pc);
    return m_valid[pc[6:4]] && (m_tag[pc[6:4]] == int'(pc[31:7]));
  endfunction

  function automatic void model_fill(input logic [31:0] pc);
    m_valid[pc[6:4]] = 1'b1;
    m_tag[pc[6:4]]   = int'(pc[31:7]);
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
  endfunction

  function automatic logic [31:0] expected_word(input logic [31:0] pc);
    logic [127:0] blk;
    blk = mem_blk[pc[9:4]];
    return blk[pc[3:2]*32 +: 32];
  endfunction

  // Presents one fetch and waits (bounded) for busywait to drop.
  task automatic do_access(input logic [31:0] pc, output int bw, output int mr,
                           output bit addr_ok, output logic [31:0] instr, output bit timeout);
    @(posedge clk); #1;
    address = pc;
    read    = 1'b1;
    bw = 0; mr = 0; addr_ok = 1'b1; timeout = 1'b1; instr = '0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (mem_read === 1'b1) begin
        mr++;
        if (mem_address !== pc[31:4]) addr_ok = 1'b0;
      end
      if (busywait === 1'b0) begin
        instr   = instruction;
        timeout = 1'b0;
        break;
      end
      bw++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; read = 1'b1; flush = 1'b0; address = 32'h0;
    #12;
    n_checks++;
    if (busywait !== 1'b0 || mem_read !== 1'b0 || instruction !== 32'h0 || mem_address !== 28'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: busywait=%b mem_read=%b instr=%h mem_addr=%h required 0/0/0/0",
               busywait, mem_read, instruction, mem_address);
    end
    read = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic test_cold_miss();
    int bw, mr; bit ok, to; logic [31:0] ins;
    do_access(32'h0, bw, mr, ok, ins, to);
    n_checks++;
    if (to || bw != 18 || mr != 16 || !ok) begin
      n_fail++;
      $display("FAIL cold_miss_timing: busy=%0d memrd=%0d addr_ok=%0b timeout=%0b required 18/16/1/0", bw, mr, ok, to);
    end
    n_checks++;
    if (ins !== 32'hC1818193) begin
      n_fail++;
      $display("FAIL cold_miss_data: got %h required C1818193", ins);
    end
    model_fill(32'h0);
  endtask

  task automatic test_hit();
    int bw, mr; bit ok, to; logic [31:0] ins;
    do_access(32'h4, bw, mr, ok, ins, to);
    n_checks++;
    if (to || bw != 0 || mr != 0) begin
      n_fail++;
      $display("FAIL hit_timing: busy=%0d memrd=%0d required 0/0", bw, mr);
    end
    n_checks++;
    if (ins !== expected_word(32'h4)) begin
      n_fail++;
      $display("FAIL hit_data: got %h required %h", ins, expected_word(32'h4));
    end
  endtask

  task automatic test_conflict();
    int bw, mr; bit ok, to; logic [31:0] ins;
    do_access(32'h80, bw, mr, ok, ins, to);
    n_checks++;
    if (to || bw != 18 || mr != 16 || !ok || ins !== expected_word(32'h80)) begin
      n_fail++;
      $display("FAIL conflict_fill: busy=%0d memrd=%0d addr_ok=%0b instr=%h required 18/16/1/%h",
               bw, mr, ok, ins, expected_word(32'h80));
    end
    model_fill(32'h80);
    do_access(32'h0, bw, mr, ok, ins, to);
    n_checks++;
    if (to || mr != 16 || ins !== expected_word(32'h0)) begin
      n_fail++;
      $display("FAIL conflict_evict: memrd=%0d instr=%h required 16/%h", mr, ins, expected_word(32'h0));
    end
    model_fill(32'h0);
  endtask

  task automatic test_flush_idle();
    int bw, mr; bit ok, to; logic [31:0] ins;
    @(posedge clk); #1;
    address = 32'h0; read = 1'b1; flush = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busywait !== 1'b1 || instruction !== 32'h0) begin
      n_fail++;
      $display("FAIL flush_idle_stall: busywait=%b instr=%h required 1/0", busywait, instruction);
    end
    @(posedge clk); #1;
    flush = 1'b0; read = 1'b0;
    model_clear();
    do_access(32'h0, bw, mr, ok, ins, to);
    n_checks++;
    if (to || mr != 16 || bw != 18 || ins !== expected_word(32'h0)) begin
      n_fail++;
      $display("FAIL flush_idle_miss: busy=%0d memrd=%0d instr=%h required 18/16/%h", bw, mr, ins, expected_word(32'h0));
    end
    model_fill(32'h0);
  endtask

  task automatic test_flush_mid_refill();
    int mr1; bit seen, done, relaunch, fin; logic [31:0] ins;
    mr1 = 0; seen = 0; done = 0; relaunch = 0; fin = 0; ins = '0;
    @(posedge clk); #1;
    address = 32'h20; read = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (mem_read === 1'b1) begin seen = 1; mr1++; end
      else if (seen) begin done = 1; break; end
      @(posedge clk); #1;
      flush = (mr1 == 5);
    end
    flush = 1'b0;
    n_checks++;
    if (!done || mr1 != 16 || busywait !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_mid_burst: done=%0b burst=%0d busywait=%b required 1/16/1", done, mr1, busywait);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (mem_read === 1'b1) begin relaunch = 1; break; end
    end
    n_checks++;
    if (!relaunch) begin
      n_fail++;
      $display("FAIL flush_mid_remiss: mem_read relaunch=%0b required 1", relaunch);
    end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (busywait === 1'b0) begin fin = 1; ins = instruction; break; end
    end
    n_checks++;
    if (!fin || ins !== expected_word(32'h20)) begin
      n_fail++;
      $display("FAIL flush_mid_refetch: done=%0b instr=%h required 1/%h", fin, ins, expected_word(32'h20));
    end
    model_clear();
    model_fill(32'h20);
  endtask

  task automatic test_reset_mid_refill();
    int mr, bw; bit ok, to, reached; logic [31:0] ins;
    mr = 0; reached = 0;
    @(posedge clk); #1;
    address = 32'h30; read = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (mem_read === 1'b1) mr++;
      if (mr == 8) begin reached = 1; break; end
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (!reached || mem_read !== 1'b0 || busywait !== 1'b0 || instruction !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid_refill: reached=%0b mem_read=%b busywait=%b instr=%h required 1/0/0/0",
               reached, mem_read, busywait, instruction);
    end
    read = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_clear();
    do_access(32'h0, bw, mr, ok, ins, to);
    n_checks++;
    if (to || mr != 16 || bw != 18 || !ok || ins !== 32'hC1818193) begin
      n_fail++;
      $display("FAIL reset_then_miss: busy=%0d memrd=%0d instr=%h required 18/16/C1818193", bw, mr, ins);
    end
    model_fill(32'h0);
  endtask

  task automatic test_random();
    int bw, mr; bit ok, to, exp_hit; logic [31:0] ins, pc, exp_w;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk); #1;
        read = 1'b0; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        model_clear();
      end else begin
        pc = ($urandom_range(0, 2) << 7) | ($urandom_range(0, 7) << 4) | ($urandom_range(0, 3) << 2);
        exp_hit = model_hit(pc);
        exp_w   = expected_word(pc);
        do_access(pc, bw, mr, ok, ins, to);
        n_checks++;
        if (to || (exp_hit && (bw != 0 || mr != 0)) || (!exp_hit && (bw != 18 || mr != 16 || !ok))) begin
          n_fail++;
          $display("FAIL rand_timing pc=%h: hit_exp=%0b busy=%0d memrd=%0d addr_ok=%0b timeout=%0b",
                   pc, exp_hit, bw, mr, ok, to);
        end
        n_checks++;
        if (ins !== exp_w) begin
          n_fail++;
          $display("FAIL rand_data pc=%h: got %h required %h", pc, ins, exp_w);
        end
        model_fill(pc);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 64; i++) mem_blk[i] = {$urandom, $urandom, $urandom, $urandom};
    mem_blk[0][31:0] = 32'hC1818193;
    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict();
    test_flush_idle();
    test_flush_mid_refill();
    test_reset_mid_refill();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
